// File: rtl/rca_share_ctrl.sv
// Round-robin sequencer sharing one external ripple-carry adder between two requesters; one op in flight.
// Latency: rsp_valid rises SETTLE cycles after acceptance; requests blocked (ready=0) until response is taken.
// Optional STICKY_OVF_EN adds per-requester sticky overflow flags (ovf_sticky / ovf_clr).
module rca_share_ctrl #(
   parameter int WIDTH  = 20,
   parameter int SETTLE = 2    // 1..15, clocks adder inputs are held before sampling
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_ovf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_ovf,
   output logic             busy
`ifdef STICKY_OVF_EN
   ,
   output logic [1:0]       ovf_sticky,
   input  logic             ovf_clr
`endif
);

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic       last_grant;
   logic       grant;
   logic       accept;
   logic       capture;
   logic       rsp_done;

   // Alternate only when both compete; a lone requester always wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else if (req1_valid)
         grant = 1'b1;
   end

   assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
   assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
   assign accept     = req0_ready || req1_ready;
   assign capture    = (state == DRIVE) && (cnt == 4'd0);
   assign rsp_done   = (state == RESP) && rsp_ready;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)   state_nxt = DRIVE;
         DRIVE:   if (capture)  state_nxt = RESP;
         RESP:    if (rsp_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= 4'd0;
         last_grant <= 1'b1;
         add_a      <= '0;
         add_b      <= '0;
         add_cin    <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_sum    <= '0;
         rsp_ovf    <= 1'b0;
         rsp_valid  <= 1'b0;
      end else begin
         if (accept) begin
            add_a      <= grant ? req1_a   : req0_a;
            add_b      <= grant ? req1_b   : req0_b;
            add_cin    <= grant ? req1_cin : req0_cin;
            rsp_id     <= grant;
            last_grant <= grant;
            cnt        <= CNT_INIT;
         end else if ((state == DRIVE) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end

         if (capture) begin
            rsp_sum   <= add_sum;
            rsp_ovf   <= add_ovf;
            rsp_valid <= 1'b1;
         end else if (rsp_done) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef STICKY_OVF_EN
   logic [1:0] sticky_set;

   // A capture in the same cycle as a clear must still leave its bit set.
   assign sticky_set = (capture && add_ovf) ? (rsp_id ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_sticky <= 2'b00;
      else
         ovf_sticky <= (ovf_clr ? 2'b00 : ovf_sticky) | sticky_set;
   end
`endif

endmodule

// File: tb/tb_rca_share_ctrl.sv
// Directed bench for rca_share_ctrl with a behavioural 20-bit adder model attached.
module tb_rca_share_ctrl;
   localparam int WIDTH  = 20;
   localparam int SETTLE = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req0_ready, req0_cin;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic             req1_valid, req1_ready, req1_cin;
   logic [WIDTH-1:0] req1_a, req1_b;
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             add_cin, add_ovf;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
   logic [WIDTH-1:0] rsp_sum;
`ifdef STICKY_OVF_EN
   logic [1:0]       ovf_sticky;
   logic             ovf_clr;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // External RCA20: sum modulo 2^20, signed overflow from operand/result signs.
   always_comb begin
      add_sum = add_a + add_b + {{(WIDTH-1){1'b0}}, add_cin};
      add_ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
   end

   rca_share_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_ovf(add_ovf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf),
      .busy(busy)
`ifdef STICKY_OVF_EN
      , .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
`endif
   );

   typedef struct {
      logic             id;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH-1:0] exp_sum;
      logic             exp_ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one op from requester id, wait for its response with rsp_ready=1 and check it.
   task automatic run_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic [WIDTH-1:0] exp_sum, input logic exp_ovf);
      int lat;
      int w;
      rsp_ready = 1'b1;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
      w = 0;
      while (!(id ? req1_ready : req0_ready) && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("accept_ready", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("drive_busy", {31'd0, busy}, 32'd1);
      chk("drive_add_a", {12'd0, add_a}, {12'd0, a});
      chk("drive_add_b", {12'd0, add_b}, {12'd0, b});
      chk("drive_add_cin", {31'd0, add_cin}, {31'd0, cin});
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      // Accept edge plus SETTLE edges -> rsp_valid seen at the (SETTLE+1)th negedge after accept.
      chk("rsp_latency", lat, SETTLE + 1);
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, id});
      chk("rsp_sum", {12'd0, rsp_sum}, {12'd0, exp_sum});
      chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, exp_ovf});
      @(negedge clk);
      chk("rsp_taken", {31'd0, rsp_valid}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int w;
      logic [WIDTH-1:0] held_sum;

      vecs[0] = '{1'b0, 20'd50,    20'd150,   1'b0, 20'd200,   1'b0};  // T1
      vecs[1] = '{1'b1, 20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b1};  // T2
      vecs[2] = '{1'b0, 20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b0};  // T6 unsigned wrap
      vecs[3] = '{1'b1, 20'h12345, 20'h54321, 1'b1, 20'h66667, 1'b0};
      vecs[4] = '{1'b0, 20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1};
      vecs[5] = '{1'b1, 20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b0};

      rst_n = 1'b0;
      req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      rsp_ready = 1'b1;
`ifdef STICKY_OVF_EN
      ovf_clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_add_a", {12'd0, add_a}, 32'd0);
      chk("rst_rsp_sum", {12'd0, rsp_sum}, 32'd0);

      // T3: both requesters valid from reset, held continuously -> ids 0,1,0,1.
      req0_a = 20'd10;  req0_b = 20'd20;  req0_cin = 1'b0;
      req1_a = 20'd100; req1_b = 20'd200; req1_cin = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("t3_first_req0_ready", {31'd0, req0_ready}, 32'd1);
      chk("t3_first_req1_ready", {31'd0, req1_ready}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         w = 0;
         while (!rsp_valid && w < 20) begin
            @(negedge clk);
            w++;
         end
         chk("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("t3_rsp_id", {31'd0, rsp_id}, k % 2);
         chk("t3_rsp_sum", {12'd0, rsp_sum}, (k % 2) ? 32'd301 : 32'd30);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_ovf);
`ifdef STICKY_OVF_EN
         if (i == 1) begin
            chk("t2_sticky", {30'd0, ovf_sticky}, 32'd2);
            ovf_clr = 1'b1;
            @(negedge clk);
            ovf_clr = 1'b0;
            chk("t2_sticky_clr", {30'd0, ovf_sticky}, 32'd0);
         end
`endif
      end

      // T4: consumer stalls for 5 cycles; response and backpressure must hold.
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 20'd5; req0_b = 20'd6; req0_cin = 1'b0;
      #1;
      chk("t4_accept", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      req0_a = 20'd7;
      req1_valid = 1'b1;
      w = 0;
      while (!rsp_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      held_sum = rsp_sum;
      chk("t4_sum", {12'd0, held_sum}, 32'd11);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("t4_hold_sum", {12'd0, rsp_sum}, {12'd0, held_sum});
         chk("t4_hold_id", {31'd0, rsp_id}, 32'd0);
         chk("t4_busy", {31'd0, busy}, 32'd1);
         chk("t4_r0_blocked", {31'd0, req0_ready}, 32'd0);
         chk("t4_r1_blocked", {31'd0, req1_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk("t4_taken", {31'd0, rsp_valid}, 32'd0);
      chk("t4_idle", {31'd0, busy}, 32'd0);

      // T5: reset during DRIVE discards the op.
      req1_valid = 1'b1; req1_a = 20'h00123; req1_b = 20'h00456; req1_cin = 1'b0;
      #1;
      chk("t5_accept", {31'd0, req1_ready}, 32'd1);
      @(negedge clk);
      req1_valid = 1'b0;
      req0_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_add_a", {12'd0, add_a}, 32'd0);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("t5_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      w = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rsp_valid) w++;
      end
      chk("t5_no_rsp", w, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("t5_rr_favours_req0", {30'd0, req1_ready, req0_ready}, 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      run_op(1'b0, 20'd1, 20'd1, 1'b1, 20'd3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
